// File: rtl/rf_wb_if.sv
// Register-file write-back bus: two producer request ports plus the staged write
// that drives the 32x32 register file's single write port.
interface rf_wb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          rdy0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          rdy1;
    logic [AW-1:0] wa;
    logic [DW-1:0] wr;
    logic          wren;
    logic          fwd_v;
    logic [AW-1:0] fwd_a;
    logic [DW-1:0] fwd_d;
    logic          gnt_last;

    modport master (
        output v0, a0, d0, v1, a1, d1,
        input  rdy0, rdy1, wa, wr, wren, fwd_v, fwd_a, fwd_d, gnt_last
    );

    modport slave (
        input  v0, a0, d0, v1, a1, d1,
        output rdy0, rdy1, wa, wr, wren, fwd_v, fwd_a, fwd_d, gnt_last
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: grants ALU (port 0) or load (port 1) into a one-entry staging register.
// Define RF_WB_RR_EN for round-robin conflict resolution; default is fixed priority to port 0.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic     clk,
    input  logic     rstd,
    rf_wb_if.slave   bus
);
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_wr_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wr;
    logic          r_wren;
    logic          r_gnt_last;

    // Grants depend only on requests and gnt_last, never on the staged write.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
`ifdef RF_WB_RR_EN
        w_gnt0 = bus.v0 & (~bus.v1 | r_gnt_last);
        w_gnt1 = bus.v1 & (~bus.v0 | ~r_gnt_last);
`else
        w_gnt0 = bus.v0;
        w_gnt1 = bus.v1 & ~bus.v0;
`endif
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_addr  = w_gnt1 ? bus.a1 : bus.a0;
    assign w_data  = w_gnt1 ? bus.d1 : bus.d0;
    // Register 0 is hardwired: the grant is consumed but nothing is staged.
    assign w_wr_en = w_any & (w_addr != '0);

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_wa       <= '0;
            r_wr       <= '0;
            r_wren     <= 1'b1;
            r_gnt_last <= 1'b1;
        end else begin
            r_wren <= ~w_wr_en;
            if (w_wr_en) begin
                r_wa <= w_addr;
                r_wr <= w_data;
            end
            if (w_any) begin
                r_gnt_last <= w_gnt1;
            end
        end
    end

    assign bus.rdy0     = w_gnt0;
    assign bus.rdy1     = w_gnt1;
    assign bus.wa       = r_wa;
    assign bus.wr       = r_wr;
    assign bus.wren     = r_wren;
    assign bus.fwd_v    = ~r_wren;
    assign bus.fwd_a    = r_wa;
    assign bus.fwd_d    = r_wr;
    assign bus.gnt_last = r_gnt_last;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected writes are queued at grant time and
// popped when the staged write appears; a register-file model checks final contents.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rstd = 1'b0;
    always #5 clk = ~clk;

    rf_wb_if #(.DW(DW), .AW(AW)) bus ();

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [AW+DW-1:0] sb_q[$];
    logic [DW-1:0] rf_m [0:31];
    logic m_gl;

    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
    end

    // Register file model: commits the staged write on the edge after it appears.
    always @(posedge clk) begin
        if (bus.wren == 1'b0) rf_m[bus.wa] <= bus.wr;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                        input logic iv1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1,
                        output logic og0, output logic og1);
        logic eg0, eg1;
        logic [AW+DW-1:0] ent;
        @(negedge clk);
        bus.v0 = iv0; bus.a0 = ia0; bus.d0 = id0;
        bus.v1 = iv1; bus.a1 = ia1; bus.d1 = id1;
        #1;
`ifdef RF_WB_RR_EN
        eg0 = iv0 && (!iv1 || m_gl == 1'b1);
        eg1 = iv1 && (!iv0 || m_gl == 1'b0);
`else
        eg0 = iv0;
        eg1 = iv1 && !iv0;
`endif
        check_eq("rdy0", bus.rdy0, eg0);
        check_eq("rdy1", bus.rdy1, eg1);
        og0 = eg0;
        og1 = eg1;
        if (eg0 && ia0 != 0) sb_q.push_back({ia0, id0});
        if (eg1 && ia1 != 0) sb_q.push_back({ia1, id1});
        if (eg0 || eg1) m_gl = eg1;
        @(posedge clk);
        #1;
        if (bus.wren == 1'b0) begin
            if (sb_q.size() == 0) begin
                check_eq("wren_unexpected", bus.wren, 1'b1);
            end else begin
                ent = sb_q.pop_front();
                check_eq("wa", bus.wa, ent[AW+DW-1:DW]);
                check_eq("wr", bus.wr, ent[DW-1:0]);
                check_eq("fwd_v", bus.fwd_v, 1'b1);
                check_eq("fwd_a", bus.fwd_a, ent[AW+DW-1:DW]);
                check_eq("fwd_d", bus.fwd_d, ent[DW-1:0]);
            end
        end else begin
            check_eq("write_missing", sb_q.size(), 0);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            check_eq("fwd_v_idle", bus.fwd_v, 1'b0);
        end
        check_eq("gnt_last", bus.gnt_last, m_gl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g0, g1;
        logic p0, p1;
        int   n0;

        m_gl = 1'b1;
        bus.v0 = 1'b1; bus.a0 = 5'd1; bus.d0 = 32'h1;
        bus.v1 = 1'b1; bus.a1 = 5'd2; bus.d1 = 32'h2;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wren", bus.wren, 1'b1);
        check_eq("rst_fwd_v", bus.fwd_v, 1'b0);
        check_eq("rst_wa", bus.wa, 0);
        check_eq("rst_wr", bus.wr, 0);
        check_eq("rst_gnt_last", bus.gnt_last, 1'b1);
        @(negedge clk);
        bus.v0 = 1'b0; bus.v1 = 1'b0;
        rstd = 1'b1;

        // First write after reset, then a single load-port write.
        step(1, 5'd5, 32'h11, 0, 0, 0, g0, g1);
        step(0, 0, 0, 1, 5'd7, 32'hDEADBEEF, g0, g1);
        step(0, 0, 0, 0, 0, 0, g0, g1);
        check_eq("rf_r7", rf_m[7], 32'hDEADBEEF);
        check_eq("rf_r5", rf_m[5], 32'h11);

        // Register 0: grant consumed, nothing staged.
        step(1, 5'd0, 32'hFFFF, 0, 0, 0, g0, g1);
        check_eq("r0_gnt_last", bus.gnt_last, 1'b0);
        step(0, 0, 0, 0, 0, 0, g0, g1);

        // Conflict for four cycles.
        n0 = 0;
        step(1, 5'd3, 32'hA, 0, 0, 0, g0, g1);
        step(0, 0, 0, 1, 5'd4, 32'hB, g0, g1);
        m_gl = 1'b1;
        step(0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, g0, g1);
            if (g0) n0++;
        end
`ifdef RF_WB_RR_EN
        check_eq("conf_n0", n0, 2);
`else
        check_eq("conf_n0", n0, 4);
`endif
        step(0, 0, 0, 0, 0, 0, g0, g1);

        // Same address from both ports; producers hold until accepted.
        p0 = 1'b1; p1 = 1'b1;
        for (int i = 0; i < 8 && (p0 || p1); i++) begin
            step(p0, 5'd9, 32'h1, p1, 5'd9, 32'h2, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        check_eq("same_done", {p0, p1}, 2'b00);
        step(0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, g0, g1);
        check_eq("rf_r9", rf_m[9], 32'h2);

        // Asynchronous reset while a write is staged.
        step(1, 5'd12, 32'h5A5A, 0, 0, 0, g0, g1);
        #2;
        rstd = 1'b0;
        #1;
        check_eq("async_wren", bus.wren, 1'b1);
        check_eq("async_fwd_v", bus.fwd_v, 1'b0);
        check_eq("async_wa", bus.wa, 0);
        check_eq("async_gnt_last", bus.gnt_last, 1'b1);
        sb_q.delete();
        m_gl = 1'b1;
        @(negedge clk);
        bus.v0 = 1'b0;
        bus.v1 = 1'b1; bus.a1 = 5'd6; bus.d1 = 32'h66;
        @(posedge clk);
        #1;
        check_eq("rf_r12_dropped", rf_m[12], 0);
        @(negedge clk);
        rstd = 1'b1;
        step(0, 0, 0, 1, 5'd6, 32'h66, g0, g1);
        check_eq("held_gnt1", g1, 1'b1);
        step(0, 0, 0, 0, 0, 0, g0, g1);
        check_eq("rf_r6", rf_m[6], 32'h66);
        check_eq("rf_r0", rf_m[0], 0);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Two producers, the ALU result path (port 0) and the load/memory return path (port 1), present writes through valid/ready handshakes. The block grants one per cycle, stages it in a one-entry output register that drives the register file's active-low write enable, and exposes the staged write as a forwarding source. Writes to register 0 are accepted but never reach the file.

## Interface
- DW, 32, data width of write data
- AW, 5, register address width
- clk  in  1  clock; all state changes on posedge
- rstd  in  1  asynchronous active-low reset
- v0  in  1  port 0 (ALU) write request valid
- a0  in  AW  port 0 destination register
- d0  in  DW  port 0 write data
- rdy0  out  1  port 0 accepted this cycle (combinational)
- v1  in  1  port 1 (load) write request valid
- a1  in  AW  port 1 destination register
- d1  in  DW  port 1 write data
- rdy1  out  1  port 1 accepted this cycle (combinational)
- wa  out  AW  register file write address (registered)
- wr  out  DW  register file write data (registered)
- wren  out  1  register file write enable, active-low (registered)
- fwd_v  out  1  staged write valid for bypass (equals ~wren)
- fwd_a  out  AW  staged write address (equals wa)
- fwd_d  out  DW  staged write data (equals wr)
- gnt_last  out  1  port index of the most recent grant (registered)

## Operation
- Handshake: a transfer on port i occurs when vi and rdyi are both 1 at a posedge. Producers hold ai/di stable while vi=1 and not accepted. rdyi never depends on a registered stall, so one transfer per cycle is always possible.
- Arbitration (combinational, each cycle):
  - Only one vi high: that port is granted.
  - Both high: resolved by the policy in Configuration.
  - Neither high: no grant; rdy0=rdy1=0.
- Staging register, loaded every posedge:
  - Grant with address != 0: wa<=a, wr<=d, wren<=0.
  - Grant with address 0: wren<=1. The grant is still consumed (rdy high), and wa/wr hold their previous values.
  - No grant: wren<=1, and wa/wr hold.
- gnt_last updates only on a grant, including a grant to address 0.
- Same-address writes from both ports in one cycle: the winner is written first and the loser in a later cycle, so the loser's value is final.
- There is no buffering beyond the staging register. A losing port keeps vi high and is retried every cycle.

## Timing
- Reset (rstd=0, asynchronous): wren=1, wa=0, wr=0, gnt_last=1 (so port 0 holds round-robin priority first), fwd_v=0. Any staged write is dropped.
- Reset deassertion mid-transfer: a request held across reset is arbitrated normally from the first posedge after release.
- Latency:
  - Request accepted at posedge N.
  - wren low and wa/wr valid between posedge N and N+1.
  - Register file commits at posedge N+1.
  - fwd_* is valid over the same window as wren.
- Throughput: one write per cycle sustained, with back-to-back wren=0 for consecutive grants.
- rdy0/rdy1 are purely combinational from v0, v1, a policy state and gnt_last. There is no combinational path from wa/wr/wren to rdy.

## Configuration
- RF_WB_RR_EN defined: round-robin policy. On conflict, the port not equal to gnt_last is granted, so continuous dual requests alternate 0,1,0,1 starting with port 0 after reset.
- RF_WB_RR_EN undefined: fixed priority. On conflict, port 0 (ALU) always wins, and port 1 waits until v0=0. gnt_last is still maintained but does not affect arbitration.

## Test plan
- Reset: hold rstd=0 with v0=v1=1 → wren=1, fwd_v=0, wa=0, wr=0. Release, then v0=1, a0=5, d0=0x11 → rdy0=1, and the next cycle shows wa=5, wr=0x11, wren=0.
- Single port: v1=1, a1=7, d1=0xDEADBEEF for one cycle → rdy1=1. wren=0 for exactly one cycle with wa=7, and the register file reads r7=0xDEADBEEF after the following edge.
- Conflict, RR build: v0=v1=1 for 4 cycles, a0=3/d0=0xA, a1=4/d1=0xB → grants 0,1,0,1 and wa sequence 3,4,3,4. Fixed build → four grants to port 0 and rdy1=0 throughout.
- Same address: v0=v1=1, a0=a1=9, d0=0x1, d1=0x2 (RR, port 0 first) → wa=9/wr=1, then wa=9/wr=2, and r9 finally holds 2.
- Register 0: v0=1, a0=0, d0=0xFFFF → rdy0=1, wren stays 1, fwd_v=0, and gnt_last=0.
- Reset mid-operation: assert rstd low while wren=0 → wren=1 immediately (asynchronous), and the staged write never commits.
